// File: rtl/vend_core_pkg.sv
// Shared definitions for the vending core: coin bit positions, denominations,
// FSM state encoding and a coin-to-value helper.
package vend_core_pkg;

  localparam int COIN_W     = 6;
  localparam int COIN_VAL_W = 10;

  localparam int COIN_5_BIT   = 0;
  localparam int COIN_10_BIT  = 1;
  localparam int COIN_25_BIT  = 2;
  localparam int COIN_50_BIT  = 3;
  localparam int COIN_100_BIT = 4;
  localparam int COIN_500_BIT = 5;

  localparam int DENOM_5   = 5;
  localparam int DENOM_10  = 10;
  localparam int DENOM_25  = 25;
  localparam int DENOM_50  = 50;
  localparam int DENOM_100 = 100;
  localparam int DENOM_500 = 500;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  // Value in cents of a one-hot coin pattern; zero for no coin.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_W-1:0] coin);
    logic [COIN_VAL_W-1:0] v;
    v = '0;
    if (coin[COIN_5_BIT])   v = COIN_VAL_W'(DENOM_5);
    if (coin[COIN_10_BIT])  v = COIN_VAL_W'(DENOM_10);
    if (coin[COIN_25_BIT])  v = COIN_VAL_W'(DENOM_25);
    if (coin[COIN_50_BIT])  v = COIN_VAL_W'(DENOM_50);
    if (coin[COIN_100_BIT]) v = COIN_VAL_W'(DENOM_100);
    if (coin[COIN_500_BIT]) v = COIN_VAL_W'(DENOM_500);
    return v;
  endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Combinational change picker: largest denomination not exceeding the given
// credit, as a one-hot coin plus its value. Zero coin when credit < 5.
module vend_change_pick
  import vend_core_pkg::*;
#(
  parameter int CREDIT_W = 11
) (
  input  logic [CREDIT_W-1:0]   credit,
  output logic [COIN_W-1:0]     coin,
  output logic [COIN_VAL_W-1:0] value
);

  // Widen to 32 bits so narrow credit widths still compare correctly against 500.
  logic [31:0] credit_w;
  assign credit_w = 32'(credit);

  // Largest-first priority selection.
  always_comb begin
    coin  = '0;
    value = '0;
    if (credit_w >= 32'(DENOM_500)) begin
      coin[COIN_500_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_500);
    end else if (credit_w >= 32'(DENOM_100)) begin
      coin[COIN_100_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_100);
    end else if (credit_w >= 32'(DENOM_50)) begin
      coin[COIN_50_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_50);
    end else if (credit_w >= 32'(DENOM_25)) begin
      coin[COIN_25_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_25);
    end else if (credit_w >= 32'(DENOM_10)) begin
      coin[COIN_10_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_10);
    end else if (credit_w >= 32'(DENOM_5)) begin
      coin[COIN_5_BIT] = 1'b1;
      value = COIN_VAL_W'(DENOM_5);
    end
  end

endmodule

// File: rtl/vend_core.sv
// Vending machine core: credit accumulation with saturation, per-slot stock,
// one-cycle VEND and a coin-per-cycle CHANGE payout (largest coin first).
// Optional idle auto-refund is built when VEND_AUTO_REFUND_EN is defined.
// Handshake note: every input is a one-cycle pulse sampled at the clock edge;
// every pulse output is a registered one-cycle strobe, there is no backpressure.
module vend_core
  import vend_core_pkg::*;
#(
  parameter int NUM_SLOTS      = 9,
  parameter int SLOT_W         = 4,
  parameter int CREDIT_W       = 11,
  parameter int MAX_CREDIT     = 2000,
  parameter int STOCK_W        = 4,
  parameter int STOCK_INIT     = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SLOTS-1:0]          slot_sel,
  input  logic [COIN_W-1:0]             coin_in,
  input  logic                          cancel,
  input  logic                          restock,
  input  logic [NUM_SLOTS*CREDIT_W-1:0] prices,
  output logic [CREDIT_W-1:0]           credit,
  output logic [NUM_SLOTS-1:0]          slot_ok,
  output logic [NUM_SLOTS-1:0]          slot_empty,
  output logic                          vend_valid,
  output logic [SLOT_W-1:0]             vend_slot,
  output logic                          deny,
  output logic [COIN_W-1:0]             coin_out,
  output logic                          coin_reject,
  output logic                          busy
);

  localparam int CW1 = CREDIT_W + 1;

  if ((SLOT_W < $clog2(NUM_SLOTS)) || (MAX_CREDIT % 5 != 0) ||
      (MAX_CREDIT >= (2 ** CREDIT_W)) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
    $error("vend_core: inconsistent parameters");
  end

  state_e                  state_q, state_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [STOCK_W-1:0]      stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0]      stock_d [NUM_SLOTS];
  logic                    vend_valid_q, vend_valid_d;
  logic [SLOT_W-1:0]       vend_slot_q, vend_slot_d;
  logic                    deny_q, deny_d;
  logic [COIN_W-1:0]       coin_out_q, coin_out_d;
  logic [COIN_VAL_W-1:0]   coin_val_q, coin_val_d;
  logic                    coin_reject_q, coin_reject_d;

  logic [CREDIT_W-1:0]     price_arr [NUM_SLOTS];
  logic [SLOT_W-1:0]       sel_idx;
  logic [CW1-1:0]          coin_sum;
  logic [COIN_W-1:0]       pick_coin;
  logic [COIN_VAL_W-1:0]   pick_val;
  logic                    timer_expired;

  // Unpack the flat price table and build the LED status vectors.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      price_arr[i]  = prices[i*CREDIT_W +: CREDIT_W];
      slot_empty[i] = (stock_q[i] == '0);
      slot_ok[i]    = (stock_q[i] != '0) && (credit_q >= price_arr[i]);
    end
  end

  // Lowest set select bit wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_sel[i]) sel_idx = SLOT_W'(i);
    end
  end

  assign coin_sum = {1'b0, credit_q} + CW1'(coin_value(coin_in));

  // FSM next state, credit, stock and pulse outputs.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    vend_valid_d  = 1'b0;
    vend_slot_d   = vend_slot_q;
    deny_d        = 1'b0;
    coin_reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel || timer_expired) begin
          if (credit_q != '0) state_d = ST_CHANGE;
        end else if (restock) begin
          for (int i = 0; i < NUM_SLOTS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end else if (coin_in != '0) begin
          if ($onehot(coin_in) && (coin_sum <= CW1'(MAX_CREDIT))) begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (slot_sel != '0) begin
          if ((stock_q[sel_idx] != '0) && (credit_q >= price_arr[sel_idx])) begin
            state_d      = ST_VEND;
            vend_valid_d = 1'b1;
            vend_slot_d  = sel_idx;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        credit_d = credit_q - price_arr[vend_slot_q];
        if (stock_q[vend_slot_q] != '0) begin
          stock_d[vend_slot_q] = stock_q[vend_slot_q] - STOCK_W'(1);
        end
        state_d       = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
        coin_reject_d = (coin_in != '0);
      end
      ST_CHANGE: begin
        // coin_out_q is the coin being paid this cycle; remove its value.
        credit_d      = credit_q - CREDIT_W'(coin_val_q);
        state_d       = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
        coin_reject_d = (coin_in != '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vend_change_pick #(
    .CREDIT_W (CREDIT_W)
  ) u_pick (
    .credit (credit_d),
    .coin   (pick_coin),
    .value  (pick_val)
  );

  // Pre-select the coin for the next cycle so it shows while CHANGE is active.
  always_comb begin
    coin_out_d = '0;
    coin_val_d = '0;
    if (state_d == ST_CHANGE) begin
      coin_out_d = pick_coin;
      coin_val_d = pick_val;
    end
  end

`ifdef VEND_AUTO_REFUND_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;

  assign timer_expired = (state_q == ST_IDLE) && (credit_q != '0) &&
                         (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Idle timer: runs only while credit is held in IDLE; any accepted coin or deny restarts it.
  always_comb begin
    timer_d = timer_q + TMR_W'(1);
    if ((state_q != ST_IDLE) || (credit_q == '0) || (credit_d != credit_q) ||
        deny_d || timer_expired) begin
      timer_d = '0;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`else
  assign timer_expired = 1'b0;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      vend_valid_q  <= 1'b0;
      vend_slot_q   <= '0;
      deny_q        <= 1'b0;
      coin_out_q    <= '0;
      coin_val_q    <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      vend_valid_q  <= vend_valid_d;
      vend_slot_q   <= vend_slot_d;
      deny_q        <= deny_d;
      coin_out_q    <= coin_out_d;
      coin_val_q    <= coin_val_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign credit      = credit_q;
  assign vend_valid  = vend_valid_q;
  assign vend_slot   = vend_slot_q;
  assign deny        = deny_q;
  assign coin_out    = coin_out_q;
  assign coin_reject = coin_reject_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_core.sv
// Self-checking bench for vend_core (default build, auto-refund disabled).
module tb_vend_core;

  localparam int NUM_SLOTS = 9;
  localparam int SLOT_W    = 4;
  localparam int CREDIT_W  = 11;

  localparam logic [5:0] C5   = 6'b000001;
  localparam logic [5:0] C10  = 6'b000010;
  localparam logic [5:0] C25  = 6'b000100;
  localparam logic [5:0] C50  = 6'b001000;
  localparam logic [5:0] C100 = 6'b010000;
  localparam logic [5:0] C500 = 6'b100000;

  logic                          clk;
  logic                          rst;
  logic [NUM_SLOTS-1:0]          slot_sel;
  logic [5:0]                    coin_in;
  logic                          cancel;
  logic                          restock;
  logic [NUM_SLOTS*CREDIT_W-1:0] prices;
  logic [CREDIT_W-1:0]           credit;
  logic [NUM_SLOTS-1:0]          slot_ok;
  logic [NUM_SLOTS-1:0]          slot_empty;
  logic                          vend_valid;
  logic [SLOT_W-1:0]             vend_slot;
  logic                          deny;
  logic [5:0]                    coin_out;
  logic                          coin_reject;
  logic                          busy;

  int checks = 0;
  int errors = 0;

  int price_tab [NUM_SLOTS] = '{25, 100, 65, 150, 5, 0, 200, 35, 1995};
  int model_stock [NUM_SLOTS];

  logic [5:0]        exp_coin_q[$];
  logic [SLOT_W-1:0] exp_vend_q[$];
  logic [0:0]        exp_deny_q[$];
  logic [0:0]        exp_rej_q[$];

  vend_core dut (
    .clk         (clk),
    .rst         (rst),
    .slot_sel    (slot_sel),
    .coin_in     (coin_in),
    .cancel      (cancel),
    .restock     (restock),
    .prices      (prices),
    .credit      (credit),
    .slot_ok     (slot_ok),
    .slot_empty  (slot_empty),
    .vend_valid  (vend_valid),
    .vend_slot   (vend_slot),
    .deny        (deny),
    .coin_out    (coin_out),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at the negedge after the sampling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_coin(input logic [5:0] c);
    coin_in = c;
    tick();
    coin_in = '0;
  endtask

  task automatic pulse_sel(input logic [NUM_SLOTS-1:0] s);
    slot_sel = s;
    tick();
    slot_sel = '0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic pulse_restock();
    restock = 1'b1;
    tick();
    restock = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) model_stock[i] = 5;
  endtask

  task automatic expect_vend(input int slot);
    exp_vend_q.push_back(SLOT_W'(slot));
    model_stock[slot] = model_stock[slot] - 1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk(tag, 32'(busy), 0);
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_coin_q"}, exp_coin_q.size(), 0);
    chk({tag, "_vend_q"}, exp_vend_q.size(), 0);
    chk({tag, "_deny_q"}, exp_deny_q.size(), 0);
    chk({tag, "_rej_q"},  exp_rej_q.size(), 0);
  endtask

  function automatic logic [NUM_SLOTS-1:0] model_ok(input int cr);
    logic [NUM_SLOTS-1:0] v;
    for (int i = 0; i < NUM_SLOTS; i++) v[i] = (model_stock[i] > 0) && (cr >= price_tab[i]);
    return v;
  endfunction

  // Scoreboard: every observed pulse output is matched against the expected queues.
  always @(negedge clk) begin
    if (vend_valid) begin
      if (exp_vend_q.size() > 0) chk("vend_slot", 32'(vend_slot), 32'(exp_vend_q.pop_front()));
      else                       chk("vend_unexpected", 32'(vend_valid), 0);
    end
    if (coin_out != '0) begin
      if (exp_coin_q.size() > 0) chk("coin_out", 32'(coin_out), 32'(exp_coin_q.pop_front()));
      else                       chk("coin_out_unexpected", 32'(coin_out), 0);
    end
    if (deny) begin
      if (exp_deny_q.size() > 0) void'(exp_deny_q.pop_front());
      else                       chk("deny_unexpected", 32'(deny), 0);
    end
    if (coin_reject) begin
      if (exp_rej_q.size() > 0) void'(exp_rej_q.pop_front());
      else                      chk("reject_unexpected", 32'(coin_reject), 0);
    end
  end

  initial begin
    rst = 1'b1; slot_sel = '0; coin_in = '0; cancel = 1'b0; restock = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      prices[i*CREDIT_W +: CREDIT_W] = CREDIT_W'(price_tab[i]);
      model_stock[i] = 5;
    end
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(slot_empty), 0);
    chk("rst_ok", 32'(slot_ok), 32'(model_ok(0)));
    chk("rst_coin_out", 32'(coin_out), 0);
    chk("rst_vend_slot", 32'(vend_slot), 0);

    // Dollar coin, vend slot 2 at 65c, change 25 + 10
    pulse_coin(C100);
    chk("s1_credit_100", 32'(credit), 100);
    expect_vend(2);
    exp_coin_q.push_back(C25);
    exp_coin_q.push_back(C10);
    pulse_sel(9'(1 << 2));
    chk("s1_vend_pulse", 32'(vend_valid), 1);
    chk("s1_busy_vend", 32'(busy), 1);
    tick();
    chk("s1_credit_35", 32'(credit), 35);
    tick();
    chk("s1_credit_10", 32'(credit), 10);
    tick();
    chk("s1_busy_low", 32'(busy), 0);
    chk("s1_credit_0", 32'(credit), 0);
    drain_check("s1");

    // Insufficient credit: deny, credit and stock untouched
    pulse_coin(C5);
    pulse_coin(C10);
    exp_deny_q.push_back(1'b1);
    pulse_sel(9'(1 << 0));
    chk("s2_deny", 32'(deny), 1);
    chk("s2_credit", 32'(credit), 15);
    chk("s2_busy", 32'(busy), 0);
    chk("s2_stock0", 32'(slot_empty[0]), 0);
    chk("s2_ok", 32'(slot_ok), 32'(model_ok(15)));
    exp_coin_q.push_back(C10);
    exp_coin_q.push_back(C5);
    pulse_cancel();
    wait_idle("s2_idle");
    chk("s2_refund_credit", 32'(credit), 0);
    drain_check("s2");

    // Drain slot 4, deny on empty, restock
    for (int k = 0; k < 5; k++) begin
      pulse_coin(C5);
      expect_vend(4);
      pulse_sel(9'(1 << 4));
      tick();
      chk("s3_vend_credit", 32'(credit), 0);
    end
    chk("s3_empty4", 32'(slot_empty[4]), 1);
    pulse_coin(C5);
    chk("s3_ok_empty", 32'(slot_ok), 32'(model_ok(5)));
    exp_deny_q.push_back(1'b1);
    pulse_sel(9'(1 << 4));
    chk("s3_deny_empty", 32'(deny), 1);
    tick();
    chk("s3_empty_still", 32'(slot_empty[4]), 1);
    pulse_restock();
    chk("s3_restock_empty", 32'(slot_empty), 0);
    chk("s3_restock_ok", 32'(slot_ok), 32'(model_ok(5)));
    exp_coin_q.push_back(C5);
    pulse_cancel();
    wait_idle("s3_idle");
    drain_check("s3");

    // Saturation and malformed coins
    for (int k = 0; k < 3; k++) pulse_coin(C500);
    for (int k = 0; k < 4; k++) pulse_coin(C100);
    chk("s4_credit_1900", 32'(credit), 1900);
    exp_rej_q.push_back(1'b1);
    pulse_coin(C500);
    chk("s4_rej_500", 32'(coin_reject), 1);
    chk("s4_credit_hold", 32'(credit), 1900);
    exp_rej_q.push_back(1'b1);
    pulse_coin(6'b000011);
    chk("s4_rej_multi", 32'(coin_reject), 1);
    chk("s4_credit_hold2", 32'(credit), 1900);
    pulse_coin(C100);
    chk("s4_credit_max", 32'(credit), 2000);
    exp_rej_q.push_back(1'b1);
    pulse_coin(C5);
    chk("s4_rej_over_max", 32'(credit), 2000);
    for (int k = 0; k < 4; k++) exp_coin_q.push_back(C500);
    pulse_cancel();
    wait_idle("s4_idle");
    chk("s4_credit_0", 32'(credit), 0);
    drain_check("s4");

    // Cancel beats a simultaneous coin; change 25, 10, 5
    pulse_coin(C25);
    pulse_coin(C10);
    pulse_coin(C5);
    chk("s5_credit_40", 32'(credit), 40);
    exp_coin_q.push_back(C25);
    exp_coin_q.push_back(C10);
    exp_coin_q.push_back(C5);
    cancel = 1'b1; coin_in = C25;
    tick();
    cancel = 1'b0; coin_in = '0;
    chk("s5_busy", 32'(busy), 1);
    chk("s5_credit_c1", 32'(credit), 40);
    tick();
    chk("s5_credit_c2", 32'(credit), 15);
    tick();
    chk("s5_credit_c3", 32'(credit), 5);
    tick();
    chk("s5_idle", 32'(busy), 0);
    chk("s5_credit_0", 32'(credit), 0);
    drain_check("s5");

    // Coin during CHANGE is rejected; reset mid-CHANGE discards credit
    pulse_coin(C100);
    pulse_coin(C25);
    exp_coin_q.push_back(C100);
    exp_coin_q.push_back(C25);
    pulse_cancel();
    exp_rej_q.push_back(1'b1);
    pulse_coin(C5);
    chk("s6_rej_change", 32'(coin_reject), 1);
    chk("s6_credit_25", 32'(credit), 25);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) model_stock[i] = 5;
    chk("s6_rst_credit", 32'(credit), 0);
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_coin", 32'(coin_out), 0);
    tick();
    chk("s6_after_credit", 32'(credit), 0);
    drain_check("s6");

    // Free slot at zero credit, multi-select lowest wins, coin beats select
    expect_vend(5);
    pulse_sel(9'(1 << 5));
    tick();
    chk("s7_free_credit", 32'(credit), 0);
    chk("s7_free_busy", 32'(busy), 0);
    pulse_coin(C25);
    pulse_coin(C10);
    chk("s7_ok_35", 32'(slot_ok), 32'(model_ok(35)));
    expect_vend(7);
    pulse_sel(9'b110000000);
    tick();
    chk("s7_multi_credit", 32'(credit), 0);
    chk("s7_multi_busy", 32'(busy), 0);
    coin_in = C10; slot_sel = 9'(1 << 5);
    tick();
    coin_in = '0; slot_sel = '0;
    chk("s7_coin_wins", 32'(credit), 10);
    chk("s7_no_vend", 32'(busy), 0);
    exp_coin_q.push_back(C10);
    pulse_cancel();
    wait_idle("s7_idle");
    chk("s7_ok_final", 32'(slot_ok), 32'(model_ok(0)));
    drain_check("s7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
